// File: rtl/u_dsram_if.sv
// rtl/u_dsram_if.sv - LSU data-memory port (dat_* bus) between LSU master and data SRAM slave
interface u_dsram_if;
    logic [31:0] dat_a;
    logic [3:0]  dat_we;
    logic [31:0] dat_wd;
    logic [3:0]  dat_re;
    logic [31:0] dat_rd;
    logic        dat_vld;
    logic        dat_err;

    modport master (
        output dat_a, dat_we, dat_wd, dat_re,
        input  dat_rd, dat_vld, dat_err
    );

    modport slave (
        input  dat_a, dat_we, dat_wd, dat_re,
        output dat_rd, dat_vld, dat_err
    );
endinterface

// File: rtl/u_dsram.sv
// rtl/u_dsram.sv - data SRAM responder with byte lanes and range error; U_DSRAM_FWD_EN enables same-cycle write-to-read forwarding
module u_dsram #(
    parameter int          AW     = 10,
    parameter logic [31:0] BASE   = 32'h0000_0000,
    parameter int          RD_LAT = 1
) (
    input logic     clk,
    input logic     rst,
    u_dsram_if.slave dat
);
    localparam int          DEPTH = 1 << AW;
    localparam logic [32:0] SIZE  = 33'(DEPTH) << 2;

    logic [31:0] mem_q [DEPTH];

    logic [32:0]   off;
    logic          in_range;
    logic          req;
    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [31:0]   rd_d;
    logic          vld_d;
    logic          err_d;

    logic          st_vld;
    logic          st_err;
    logic [31:0]   st_rd;

    logic          vld_q;
    logic          err_q;
    logic [31:0]   rd_q;

    // Decode the request: 33-bit offset makes addresses below BASE huge, so one compare covers both bounds
    always_comb begin
        off      = {1'b0, dat.dat_a} - {1'b0, BASE};
        in_range = off < SIZE;
        idx      = off[AW+1:2];
        req      = (|dat.dat_we) || (|dat.dat_re);
        word     = mem_q[idx];
        rd_d     = '0;
        for (int i = 0; i < 4; i++) begin
            if (dat.dat_re[i] && in_range) begin
                rd_d[8*i +: 8] = word[8*i +: 8];
`ifdef U_DSRAM_FWD_EN
                if (dat.dat_we[i]) begin
                    rd_d[8*i +: 8] = dat.dat_wd[8*i +: 8];
                end
`endif
            end
        end
        vld_d = |dat.dat_re;
        err_d = req && !in_range;
    end

    // Array write: masked lanes only, not gated by rst so contents survive reset
    always_ff @(posedge clk) begin
        if (in_range) begin
            for (int i = 0; i < 4; i++) begin
                if (dat.dat_we[i]) begin
                    mem_q[idx][8*i +: 8] <= dat.dat_wd[8*i +: 8];
                end
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic        p_vld_q;
            logic        p_err_q;
            logic [31:0] p_rd_q;

            // Extra response stage for the two-cycle latency build
            always_ff @(posedge clk) begin
                if (rst) begin
                    p_vld_q <= 1'b0;
                    p_err_q <= 1'b0;
                    p_rd_q  <= '0;
                end else begin
                    p_vld_q <= vld_d;
                    p_err_q <= err_d;
                    p_rd_q  <= rd_d;
                end
            end

            assign st_vld = p_vld_q;
            assign st_err = p_err_q;
            assign st_rd  = p_rd_q;
        end else begin : g_lat1
            assign st_vld = vld_d;
            assign st_err = err_d;
            assign st_rd  = rd_d;
        end
    endgenerate

    // Output stage: vld/err pulse per request, rd only reloads on a read response
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= 1'b0;
            err_q <= 1'b0;
            rd_q  <= '0;
        end else begin
            vld_q <= st_vld;
            err_q <= st_err;
            if (st_vld) begin
                rd_q <= st_rd;
            end
        end
    end

    assign dat.dat_rd  = rd_q;
    assign dat.dat_vld = vld_q;
    assign dat.dat_err = err_q;
endmodule
